// File: rtl/local_inject_arbiter.sv
// local_inject_arbiter
// Round-robin arbiter that lets N traffic injectors share one router Local
// input port. Each injector uses a four-phase Req/Gnt handshake. The arbiter
// latches the winning packet so the router sees a stable flit while the
// request is pending, then returns a one-cycle grant pulse to the winner.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   ReqIn      per-injector request (bit i = injector i)
//   PacketIn   per-injector packet, injector i at [i*dataWidth +: dataWidth]
//   GntOut     one-cycle grant pulse to the winning injector
//   FullOut    router full, copied combinationally to every injector
//   ReqRtr     request to the router Local port
//   GntRtr     grant from the router Local port
//   RtrFull    router Local FIFO full
//   PacketRtr  latched packet presented to the router
//   Busy       high whenever the arbiter is not idle
//   GrantCount number of packets forwarded since reset (wraps)
module local_inject_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned dataWidth = 32,
  parameter int unsigned PTR_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           ReqIn,
  input  logic [N*dataWidth-1:0] PacketIn,
  output logic [N-1:0]           GntOut,
  output logic [N-1:0]           FullOut,
  output logic                   ReqRtr,
  input  logic                   GntRtr,
  input  logic                   RtrFull,
  output logic [dataWidth-1:0]   PacketRtr,
  output logic                   Busy,
  output logic [31:0]            GrantCount
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_GRANT    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       r_win;
  logic                   r_req_rtr;
  logic [N-1:0]           r_gnt;
  logic [dataWidth-1:0]   r_pkt;
  logic                   r_busy;
  logic [31:0]            r_cnt;

  logic [PTR_W:0]         w_shift;
  logic [2*N-1:0]         w_rot;
  logic                   w_any;
  int unsigned            w_off;
  logic [PTR_W-1:0]       w_win;
  logic [dataWidth-1:0]   w_pkt;

  // Rotate requests so that bit 0 is the requester just after the last winner.
  assign w_shift = {1'b0, r_ptr} + (PTR_W+1)'(1);
  assign w_rot   = {ReqIn, ReqIn} >> w_shift;

  // First set bit in rotated order picks the winner.
  always_comb begin
    w_any = 1'b0;
    w_off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any = 1'b1;
        w_off = 32'(i);
      end
    end
    w_win = PTR_W'((32'(r_ptr) + 32'd1 + w_off) % N);
  end

  // Select the winner's packet slice.
  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < N; i++) begin
      if (PTR_W'(i) == w_win) w_pkt = PacketIn[i*dataWidth +: dataWidth];
    end
  end

  // Arbitration FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= PTR_W'(N - 1);
      r_win     <= '0;
      r_req_rtr <= 1'b0;
      r_gnt     <= '0;
      r_pkt     <= '0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any && !RtrFull) begin
            r_pkt     <= w_pkt;
            r_win     <= w_win;
            r_req_rtr <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_WAIT_GNT;
          end
        end
        // Request is held regardless of RtrFull until the router grants.
        S_WAIT_GNT: begin
          if (GntRtr) begin
            r_req_rtr <= 1'b0;
            r_gnt     <= N'(1) << r_win;
            r_ptr     <= r_win;
            r_cnt     <= r_cnt + 32'd1;
            r_state   <= S_GRANT;
          end
        end
        // One cycle of grant lets the injector drop Req before re-arbitration.
        S_GRANT: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign GntOut     = r_gnt;
  assign FullOut    = {N{RtrFull}};
  assign ReqRtr     = r_req_rtr;
  assign PacketRtr  = r_pkt;
  assign Busy       = r_busy;
  assign GrantCount = r_cnt;

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Directed bench for local_inject_arbiter: single request, contention,
// fairness, router full, reset mid-transfer and late full.
module tb_local_inject_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    ReqIn;
  logic [N*DW-1:0] PacketIn;
  logic [N-1:0]    GntOut;
  logic [N-1:0]    FullOut;
  logic            ReqRtr;
  logic            GntRtr;
  logic            RtrFull;
  logic [DW-1:0]   PacketRtr;
  logic            Busy;
  logic [31:0]     GrantCount;

  int errors = 0;
  int checks = 0;

  local_inject_arbiter #(.N(N), .dataWidth(DW), .PTR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqIn      (ReqIn),
    .PacketIn   (PacketIn),
    .GntOut     (GntOut),
    .FullOut    (FullOut),
    .ReqRtr     (ReqRtr),
    .GntRtr     (GntRtr),
    .RtrFull    (RtrFull),
    .PacketRtr  (PacketRtr),
    .Busy       (Busy),
    .GrantCount (GrantCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    ReqIn   = '0;
    GntRtr  = 1'b0;
    RtrFull = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // One transfer with an immediate router grant; returns the observed grant.
  task automatic xfer(input logic drop, output logic [N-1:0] g);
    tick();
    check_val("xfer_req_rtr", 32'(ReqRtr), 32'd1);
    GntRtr = 1'b1;
    tick();
    g = GntOut;
    check_val("xfer_req_drop", 32'(ReqRtr), 32'd0);
    GntRtr = 1'b0;
    if (drop) ReqIn = ReqIn & ~g;
    tick();
    check_val("xfer_gnt_clear", 32'(GntOut), 32'd0);
    check_val("xfer_idle", 32'(Busy), 32'd0);
  endtask

  logic [N-1:0] g;
  logic [3:0]   exp_order [4];

  initial begin
    for (int i = 0; i < N; i++) PacketIn[i*DW +: DW] = 32'h3B00_0001 + 32'(i) * 32'h10;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100; exp_order[3] = 4'b1000;

    // Reset values
    do_reset();
    check_val("rst_req_rtr", 32'(ReqRtr), 32'd0);
    check_val("rst_gnt", 32'(GntOut), 32'd0);
    check_val("rst_pkt", PacketRtr, 32'd0);
    check_val("rst_busy", 32'(Busy), 32'd0);
    check_val("rst_cnt", GrantCount, 32'd0);

    // 1. Single request, router grants two cycles after ReqRtr
    ReqIn = 4'b0001;
    tick();
    check_val("t1_req_rtr", 32'(ReqRtr), 32'd1);
    check_val("t1_busy", 32'(Busy), 32'd1);
    check_val("t1_pkt", PacketRtr, 32'h3B00_0001);
    tick();
    check_val("t1_req_hold", 32'(ReqRtr), 32'd1);
    check_val("t1_pkt_hold", PacketRtr, 32'h3B00_0001);
    check_val("t1_no_gnt", 32'(GntOut), 32'd0);
    GntRtr = 1'b1;
    tick();
    check_val("t1_gnt", 32'(GntOut), 32'b0001);
    check_val("t1_req_low", 32'(ReqRtr), 32'd0);
    check_val("t1_cnt", GrantCount, 32'd1);
    GntRtr = 1'b0;
    ReqIn  = 4'b0000;
    tick();
    check_val("t1_gnt_pulse", 32'(GntOut), 32'd0);
    check_val("t1_busy_end", 32'(Busy), 32'd0);

    // 2. Full contention, grants in order 0..3, 12 cycles total
    do_reset();
    ReqIn = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      xfer(1'b1, g);
      check_val($sformatf("t2_order%0d", k), 32'(g), 32'(exp_order[k]));
    end
    check_val("t2_cnt", GrantCount, 32'd4);

    // 3. Fairness: requesters 1 and 3 always requesting
    do_reset();
    ReqIn = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      xfer(1'b0, g);
      check_val($sformatf("t3_alt%0d", k), 32'(g), (k % 2 == 0) ? 32'b0010 : 32'b1000);
    end
    check_val("t3_cnt", GrantCount, 32'd8);

    // 4. Router full blocks arbitration
    do_reset();
    RtrFull = 1'b1;
    ReqIn   = 4'b0100;
    #1;
    check_val("t4_fullout", 32'(FullOut), 32'b1111);
    tick();
    tick();
    check_val("t4_req_blocked", 32'(ReqRtr), 32'd0);
    check_val("t4_busy_blocked", 32'(Busy), 32'd0);
    RtrFull = 1'b0;
    #1;
    check_val("t4_fullout_clr", 32'(FullOut), 32'b0000);
    tick();
    check_val("t4_req_rtr", 32'(ReqRtr), 32'd1);
    check_val("t4_pkt", PacketRtr, 32'h3B00_0021);
    GntRtr = 1'b1;
    tick();
    check_val("t4_gnt", 32'(GntOut), 32'b0100);
    GntRtr = 1'b0;
    ReqIn  = 4'b0000;
    tick();

    // 5. Reset while waiting for router grant
    do_reset();
    ReqIn = 4'b0001;
    xfer(1'b1, g);
    check_val("t5_first", 32'(g), 32'b0001);
    ReqIn = 4'b0010;
    tick();
    check_val("t5_wait", 32'(ReqRtr), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_val("t5_rst_req", 32'(ReqRtr), 32'd0);
    check_val("t5_rst_gnt", 32'(GntOut), 32'd0);
    check_val("t5_rst_cnt", GrantCount, 32'd0);
    check_val("t5_rst_busy", 32'(Busy), 32'd0);
    ReqIn = 4'b1000;
    tick();
    reset = 1'b1;
    tick();
    check_val("t5_pkt3", PacketRtr, 32'h3B00_0031);
    GntRtr = 1'b1;
    tick();
    check_val("t5_gnt3", 32'(GntOut), 32'b1000);
    GntRtr = 1'b0;
    ReqIn  = 4'b0000;
    tick();

    // 6. Router full rising while waiting for grant
    do_reset();
    ReqIn = 4'b0010;
    tick();
    check_val("t6_req", 32'(ReqRtr), 32'd1);
    RtrFull = 1'b1;
    PacketIn[1*DW +: DW] = 32'hDEAD_BEEF;
    tick();
    tick();
    check_val("t6_req_hold", 32'(ReqRtr), 32'd1);
    check_val("t6_pkt_hold", PacketRtr, 32'h3B00_0011);
    check_val("t6_no_gnt", 32'(GntOut), 32'd0);
    GntRtr = 1'b1;
    tick();
    check_val("t6_gnt", 32'(GntOut), 32'b0010);
    GntRtr = 1'b0;
    ReqIn  = 4'b0000;
    tick();
    check_val("t6_gnt_clr", 32'(GntOut), 32'd0);
    tick();
    check_val("t6_gnt_still", 32'(GntOut), 32'd0);
    check_val("t6_cnt", GrantCount, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
